// File: rtl/led_axi_pkg.sv
// Shared constants, state types and address decode for the LED AXI4-Lite slave.
package led_axi_pkg;

    localparam logic [3:0] OFF_LED    = 4'h0;
    localparam logic [3:0] OFF_WCOUNT = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    typedef enum logic [1:0] {REG_LED, REG_WCOUNT, REG_CTRL, REG_NONE} reg_sel_t;

    // Word-aligned decode of the low off_bits address bits; bits [1:0] and
    // everything above off_bits are ignored.
    function automatic reg_sel_t decode(input logic [31:0] addr, input int unsigned off_bits);
        logic [31:0] off;
        off = '0;
        for (int unsigned i = 2; i < 32; i++) begin
            if (i < off_bits) off[i] = addr[i];
        end
        if (off == 32'(OFF_LED))         decode = REG_LED;
        else if (off == 32'(OFF_WCOUNT)) decode = REG_WCOUNT;
        else if (off == 32'(OFF_CTRL))   decode = REG_CTRL;
        else                             decode = REG_NONE;
    endfunction

endpackage

// File: rtl/led_axi_regfile.sv
// Register storage for the LED slave: LED pattern, write counter and control.
module led_axi_regfile
    import led_axi_pkg::*;
#(
    parameter int unsigned LED_WIDTH   = 16,
    parameter logic [31:0] LED_RESET   = 32'h0000_0000,
    parameter int unsigned OFFSET_BITS = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 wr_en,
    input  logic [31:0]          wr_addr,
    input  logic [31:0]          wr_data,
    input  logic [3:0]           wr_strb,
    output logic [1:0]           wr_resp,
    input  logic [31:0]          rd_addr,
    output logic [31:0]          rd_data,
    output logic [1:0]           rd_resp,
    output logic [LED_WIDTH-1:0] led_q,
    output logic                 invert
);

    logic [31:0]          wcount_q;
    logic [LED_WIDTH-1:0] led_nxt;
    reg_sel_t             wr_sel;
    reg_sel_t             rd_sel;
    logic                 unused_bits;

    assign wr_sel      = decode(wr_addr, OFFSET_BITS);
    assign rd_sel      = decode(rd_addr, OFFSET_BITS);
    assign unused_bits = ^{wr_data, wr_addr, rd_addr};

    // Response code for the write currently presented
    always_comb begin
        wr_resp = RESP_DECERR;
        case (wr_sel)
            REG_LED, REG_CTRL: wr_resp = RESP_OKAY;
            REG_WCOUNT:        wr_resp = RESP_SLVERR;
            default:           wr_resp = RESP_DECERR;
        endcase
    end

    // Byte-lane merge of write data over the current LED value
    always_comb begin
        led_nxt = led_q;
        for (int unsigned i = 0; i < LED_WIDTH; i++) begin
            if (wr_strb[i / 8]) led_nxt[i] = wr_data[i];
        end
    end

    // Register updates on a committed write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q    <= LED_RESET[LED_WIDTH-1:0];
            wcount_q <= '0;
            invert   <= 1'b0;
        end else if (wr_en) begin
            case (wr_sel)
                REG_LED: begin
                    led_q    <= led_nxt;
                    wcount_q <= wcount_q + 32'd1;
                end
                REG_CTRL: begin
                    if (wr_strb[0]) invert <= wr_data[0];
                end
                default: ;
            endcase
        end
    end

    // Read mux, sampled by the read FSM at the handshake edge
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (rd_sel)
            REG_LED:    rd_data = 32'(led_q);
            REG_WCOUNT: rd_data = wcount_q;
            REG_CTRL:   rd_data = {31'b0, invert};
            default:    rd_resp = RESP_DECERR;
        endcase
    end

endmodule

// File: rtl/led_axi_slave.sv
// AXI4-Lite responder driving the board LEDs; holds the write and read FSMs.
module led_axi_slave
    import led_axi_pkg::*;
#(
    parameter int unsigned LED_WIDTH   = 16,
    parameter logic [31:0] LED_RESET   = 32'h0000_0000,
    parameter int unsigned OFFSET_BITS = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    output logic [LED_WIDTH-1:0] led,
    input  logic [31:0]          S_AXI_AWADDR,
    input  logic                 S_AXI_AWVALID,
    output logic                 S_AXI_AWREADY,
    input  logic [31:0]          S_AXI_WDATA,
    input  logic [3:0]           S_AXI_WSTRB,
    input  logic                 S_AXI_WVALID,
    output logic                 S_AXI_WREADY,
    output logic [1:0]           S_AXI_BRESP,
    output logic                 S_AXI_BVALID,
    input  logic                 S_AXI_BREADY,
    input  logic [31:0]          S_AXI_ARADDR,
    input  logic                 S_AXI_ARVALID,
    output logic                 S_AXI_ARREADY,
    output logic [31:0]          S_AXI_RDATA,
    output logic [1:0]           S_AXI_RRESP,
    output logic                 S_AXI_RVALID,
    input  logic                 S_AXI_RREADY
);

    wr_state_t            wstate;
    rd_state_t            rstate;
    logic                 aw_held, w_held;
    logic [31:0]          awaddr_q, wdata_q;
    logic [3:0]           wstrb_q;
    logic                 aw_hs, w_hs, have_aw, have_w, wr_en;
    logic [31:0]          wr_addr, wr_data, rd_data;
    logic [3:0]           wr_strb;
    logic [1:0]           wr_resp, rd_resp;
    logic [LED_WIDTH-1:0] led_q;
    logic                 invert;

    assign aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs    = S_AXI_WVALID & S_AXI_WREADY;
    assign have_aw = aw_held | aw_hs;
    assign have_w  = w_held | w_hs;
    // Commit on the edge where the later of AW/W is captured, bypassing the
    // holding registers for whichever beat arrives on that edge.
    assign wr_en   = (wstate == W_IDLE) & have_aw & have_w;
    assign wr_addr = aw_held ? awaddr_q : S_AXI_AWADDR;
    assign wr_data = w_held ? wdata_q : S_AXI_WDATA;
    assign wr_strb = w_held ? wstrb_q : S_AXI_WSTRB;

    assign led = led_q ^ {LED_WIDTH{invert}};

    led_axi_regfile #(
        .LED_WIDTH  (LED_WIDTH),
        .LED_RESET  (LED_RESET),
        .OFFSET_BITS(OFFSET_BITS)
    ) u_regfile (
        .clk    (clk),
        .resetn (resetn),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_strb(wr_strb),
        .wr_resp(wr_resp),
        .rd_addr(S_AXI_ARADDR),
        .rd_data(rd_data),
        .rd_resp(rd_resp),
        .led_q  (led_q),
        .invert (invert)
    );

    // Write channel FSM: capture AW/W in any order, commit, then hold B
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wstate        <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (have_aw && have_w) begin
                        S_AXI_BVALID  <= 1'b1;
                        S_AXI_BRESP   <= wr_resp;
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b0;
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        wstate        <= W_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_held  <= 1'b1;
                            awaddr_q <= S_AXI_AWADDR;
                        end
                        if (w_hs) begin
                            w_held  <= 1'b1;
                            wdata_q <= S_AXI_WDATA;
                            wstrb_q <= S_AXI_WSTRB;
                        end
                        S_AXI_AWREADY <= !have_aw;
                        S_AXI_WREADY  <= !have_w;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_BRESP   <= RESP_OKAY;
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                        wstate        <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM: sample the register mux at the AR handshake, hold R
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rstate        <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                        S_AXI_RDATA   <= rd_data;
                        S_AXI_RRESP   <= rd_resp;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_ARREADY <= 1'b0;
                        rstate        <= R_DATA;
                    end else begin
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                        rstate        <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_axi_slave.sv
// Directed self-checking bench for led_axi_slave.
module tb_led_axi_slave;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] led;
    logic [31:0] S_AXI_AWADDR = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b1;
    logic [31:0] S_AXI_ARADDR = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_axi_slave #(
        .LED_WIDTH  (16),
        .LED_RESET  (32'h0000_0000),
        .OFFSET_BITS(4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .led          (led),
        .S_AXI_AWADDR (S_AXI_AWADDR),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .S_AXI_WSTRB  (S_AXI_WSTRB),
        .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_BRESP  (S_AXI_BRESP),
        .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY),
        .S_AXI_ARADDR (S_AXI_ARADDR),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA  (S_AXI_RDATA),
        .S_AXI_RRESP  (S_AXI_RRESP),
        .S_AXI_RVALID (S_AXI_RVALID),
        .S_AXI_RREADY (S_AXI_RREADY)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge. Returns at the negedge after B completes (or, with
    // BREADY low, at the negedge where BVALID is first seen).
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        int n = 0;
        S_AXI_AWADDR  = a;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = d;
        S_AXI_WSTRB   = s;
        S_AXI_WVALID  = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            if (S_AXI_AWREADY && S_AXI_AWVALID) aw_done = 1;
            if (S_AXI_WREADY && S_AXI_WVALID)   w_done  = 1;
            @(negedge clk);
            if (aw_done) S_AXI_AWVALID = 1'b0;
            if (w_done)  S_AXI_WVALID  = 1'b0;
            n++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        if (n >= 20) check("write_timeout", 32'd1, 32'd0);
        check("bvalid_latency", 32'(S_AXI_BVALID), 32'd1);
        resp = S_AXI_BRESP;
        if (S_AXI_BREADY) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after R completes.
    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        while (!S_AXI_ARREADY && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("read_timeout", 32'd1, 32'd0);
        @(negedge clk);
        S_AXI_ARVALID = 1'b0;
        check("rvalid_latency", 32'(S_AXI_RVALID), 32'd1);
        d    = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        if (S_AXI_RREADY) @(negedge clk);
    endtask

    initial begin
        logic [1:0]  r;
        logic [31:0] d;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_handshake", {27'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY,
                                S_AXI_BVALID, S_AXI_RVALID}, 32'd0);
        check("rst_resp", {28'b0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
        check("rst_rdata", S_AXI_RDATA, 32'd0);
        check("rst_led", 32'(led), 32'd0);
        resetn = 1'b1;
        #1 check("ready_pre_edge", 32'(S_AXI_AWREADY), 32'd0);
        @(negedge clk);
        check("ready_first_edge", {29'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);

        // 1: AW and W together
        do_write(32'h1000, 32'h0000_A5A5, 4'hF, r);
        check("t1_bresp", 32'(r), 32'd0);
        check("t1_led", 32'(led), 32'h0000_A5A5);
        do_read(32'h4, d, r);
        check("t1_wcount", d, 32'd1);

        // 2: W three cycles ahead of AW, lane 1 only
        S_AXI_WDATA  = 32'h0000_1234;
        S_AXI_WSTRB  = 4'h2;
        S_AXI_WVALID = 1'b1;
        @(negedge clk);
        S_AXI_WVALID = 1'b0;
        check("t2_wready_drop", {30'b0, S_AXI_WREADY, S_AXI_AWREADY}, 32'h1);
        repeat (2) @(negedge clk);
        check("t2_led_before", 32'(led), 32'h0000_A5A5);
        check("t2_no_bvalid", 32'(S_AXI_BVALID), 32'd0);
        S_AXI_AWADDR  = 32'h0;
        S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        S_AXI_AWVALID = 1'b0;
        check("t2_bvalid", 32'(S_AXI_BVALID), 32'd1);
        check("t2_bresp", 32'(S_AXI_BRESP), 32'd0);
        check("t2_led", 32'(led), 32'h0000_12A5);
        @(negedge clk);
        check("t2_bvalid_drop", 32'(S_AXI_BVALID), 32'd0);

        // 3: CTRL, SLVERR, DECERR
        do_write(32'h8, 32'h1, 4'h1, r);
        check("t3_ctrl_bresp", 32'(r), 32'd0);
        check("t3_led_inv", 32'(led), 32'h0000_ED5A);
        do_read(32'h8, d, r);
        check("t3_ctrl_rdata", d, 32'd1);
        check("t3_ctrl_rresp", 32'(r), 32'd0);
        do_write(32'h4, 32'hDEAD_BEEF, 4'hF, r);
        check("t3_wcount_slverr", 32'(r), 32'h2);
        do_read(32'h4, d, r);
        check("t3_wcount_kept", d, 32'd2);
        do_read(32'hC, d, r);
        check("t3_c_rdata", d, 32'd0);
        check("t3_c_rresp", 32'(r), 32'h3);
        do_write(32'hC, 32'hFFFF_FFFF, 4'hF, r);
        check("t3_c_bresp", 32'(r), 32'h3);
        do_read(32'h1002, d, r);
        check("t3_led_rd_unaligned", d, 32'h0000_12A5);

        // 4: BREADY stalled, concurrent read
        S_AXI_BREADY = 1'b0;
        do_write(32'h0, 32'h0000_00FF, 4'h1, r);
        check("t4_bresp", 32'(r), 32'd0);
        check("t4_led", 32'(led), 32'h0000_ED00);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_a", {28'b0, S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY | S_AXI_WREADY}, 32'h8);
            @(negedge clk);
        end
        do_read(32'h0, d, r);
        check("t4_rd_during_stall", d, 32'h0000_12FF);
        check("t4_rresp", 32'(r), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_b", {28'b0, S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY | S_AXI_WREADY}, 32'h8);
            @(negedge clk);
        end
        S_AXI_BREADY = 1'b1;
        @(negedge clk);
        check("t4_release", {29'b0, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 32'h3);
        do_read(32'h4, d, r);
        check("t4_wcount", d, 32'd3);

        // 5: counter wrap, strobe-less LED write still counts
        dut.u_regfile.wcount_q = 32'hFFFF_FFFF;
        do_read(32'h4, d, r);
        check("t5_preload", d, 32'hFFFF_FFFF);
        do_write(32'h0, 32'h0000_0000, 4'h0, r);
        check("t5_bresp", 32'(r), 32'd0);
        do_read(32'h4, d, r);
        check("t5_wrap", d, 32'd0);
        do_read(32'h0, d, r);
        check("t5_led_nostrb", d, 32'h0000_12FF);

        // 6: reset while BVALID pending
        S_AXI_BREADY = 1'b0;
        do_write(32'h8, 32'h0, 4'h1, r);
        check("t6_led_noinv", 32'(led), 32'h0000_12FF);
        #2 resetn = 1'b0;
        #1;
        check("t6_bvalid_async", 32'(S_AXI_BVALID), 32'd0);
        check("t6_led_reset", 32'(led), 32'd0);
        check("t6_ready_low", {30'b0, S_AXI_AWREADY, S_AXI_ARREADY}, 32'd0);
        S_AXI_BREADY = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("t6_ready_after", {28'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID}, 32'hE);
        do_read(32'h4, d, r);
        check("t6_wcount_reset", d, 32'd0);
        do_read(32'h0, d, r);
        check("t6_led_reg_reset", d, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
